// File: rtl/vp_pkg.sv
// vp_pkg: shared definitions for the video poker machine.
//   - vp_state_e : round sequencer state encoding (also exported on the GUI state port)
//   - HV_*       : hand-value constants produced by the resolver (0..9)
//   - vp_mult()  : payout multiplier per hand value; values 10..15 pay nothing
package vp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEBIT     = 3'd1,
    ST_WAIT_DEAL = 3'd2,
    ST_HOLD      = 3'd3,
    ST_WAIT_RES  = 3'd4,
    ST_PAYOUT    = 3'd5
  } vp_state_e;

  localparam logic [3:0] HV_NOTHING        = 4'd0;
  localparam logic [3:0] HV_JACKS_OR_BETTER = 4'd1;
  localparam logic [3:0] HV_TWO_PAIR       = 4'd2;
  localparam logic [3:0] HV_THREE_KIND     = 4'd3;
  localparam logic [3:0] HV_STRAIGHT       = 4'd4;
  localparam logic [3:0] HV_FLUSH          = 4'd5;
  localparam logic [3:0] HV_FULL_HOUSE     = 4'd6;
  localparam logic [3:0] HV_FOUR_KIND      = 4'd7;
  localparam logic [3:0] HV_STRAIGHT_FLUSH = 4'd8;
  localparam logic [3:0] HV_ROYAL_FLUSH    = 4'd9;

  function automatic logic [7:0] vp_mult(input logic [3:0] v);
    logic [7:0] m;
    case (v)
      HV_NOTHING:         m = 8'd0;
      HV_JACKS_OR_BETTER: m = 8'd1;
      HV_TWO_PAIR:        m = 8'd2;
      HV_THREE_KIND:      m = 8'd3;
      HV_STRAIGHT:        m = 8'd4;
      HV_FLUSH:           m = 8'd6;
      HV_FULL_HOUSE:      m = 8'd9;
      HV_FOUR_KIND:       m = 8'd25;
      HV_STRAIGHT_FLUSH:  m = 8'd50;
      HV_ROYAL_FLUSH:     m = 8'd250;
      default:            m = 8'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vp_payout_ctr.sv
// vp_payout_ctr: remaining-payout counter.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   load_i           : load load_val_i (takes priority over decrement)
//   load_val_i [W]   : payout amount for the round
//   dec_i            : decrement by one while non-zero
//   done_o           : remaining count is zero
module vp_payout_ctr #(
  parameter int unsigned W = 12
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = load_val_i;
    end else if (dec_i && (rem_q != '0)) begin
      rem_d = rem_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign done_o = (rem_q == '0);

endmodule

// File: rtl/vp_game_ctrl.sv
// vp_game_ctrl: round sequencer and credit manager for the video poker machine.
// Optional feature macro: VP_AUTO_DRAW_EN (auto-draw after HOLD_TIMEOUT cycles in HOLD).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   coin                  : +1 credit pulse (any state)
//   bet_btn/deal_btn/draw_btn : player button pulses
//   dealt, resolved, value: handshakes from play/resolver; value valid with resolved
//   gui_deal, gui_draw    : one-cycle requests to play
//   credits, bet, win     : credit count, current bet, last round payout
//   state, busy           : FSM state for GUI/debug, high when not IDLE
module vp_game_ctrl
  import vp_pkg::*;
#(
  parameter int unsigned CREDIT_W     = 12,
  parameter int unsigned MAX_BET      = 5,
  parameter int unsigned HOLD_TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin,
  input  logic                bet_btn,
  input  logic                deal_btn,
  input  logic                draw_btn,
  input  logic                dealt,
  input  logic                resolved,
  input  logic [3:0]          value,
  output logic                gui_deal,
  output logic                gui_draw,
  output logic [CREDIT_W-1:0] credits,
  output logic [2:0]          bet,
  output logic [CREDIT_W-1:0] win,
  output logic [2:0]          state,
  output logic                busy
);

  localparam int unsigned SW = CREDIT_W + 2;

  vp_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [CREDIT_W-1:0] win_q, win_d;
  logic [2:0]          bet_q, bet_d;
  logic                gui_deal_q, gui_deal_d;
  logic                gui_draw_q, gui_draw_d;
  logic                busy_q, busy_d;
  logic                pay_load, pay_done, pay_tick;
  logic                draw_req;
  logic [10:0]         prod;
  logic [SW-1:0]       csum;

`ifdef VP_AUTO_DRAW_EN
  localparam int unsigned HCW = $clog2(HOLD_TIMEOUT) + 1;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = (state_q == ST_HOLD) ? hold_cnt_q + HCW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign draw_req = draw_btn | (hold_cnt_q == HCW'(HOLD_TIMEOUT - 1));
`else
  logic [31:0] unused_hold_timeout;
  assign unused_hold_timeout = 32'(HOLD_TIMEOUT);
  assign draw_req = draw_btn;
`endif

  // Product <= 7*250 = 1750, fits 11 bits.
  assign prod     = 11'(bet_q) * 11'(vp_mult(value));
  assign pay_tick = (state_q == ST_PAYOUT) && !pay_done;

  vp_payout_ctr #(.W(CREDIT_W)) u_payout_ctr (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (pay_load),
    .load_val_i (win_d),
    .dec_i      (state_q == ST_PAYOUT),
    .done_o     (pay_done)
  );

  always_comb begin
    state_d  = state_q;
    bet_d    = bet_q;
    win_d    = win_q;
    pay_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An accepted deal freezes the bet so the debited amount is unambiguous.
        if (deal_btn && (credits_q >= CREDIT_W'(bet_q))) begin
          state_d = ST_DEBIT;
        end else if (bet_btn) begin
          bet_d = (bet_q == 3'(MAX_BET)) ? 3'd1 : bet_q + 3'd1;
        end
      end
      ST_DEBIT: begin
        win_d   = '0;
        state_d = ST_WAIT_DEAL;
      end
      ST_WAIT_DEAL: if (dealt)    state_d = ST_HOLD;
      ST_HOLD:      if (draw_req) state_d = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (resolved) begin
          win_d    = CREDIT_W'(prod);
          pay_load = 1'b1;
          state_d  = ST_PAYOUT;
        end
      end
      ST_PAYOUT:    if (pay_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Two guard bits absorb coin + payout tick; debit cannot underflow since
    // DEBIT is only entered with credits >= bet and credits never decrease otherwise.
    csum = SW'(credits_q) + SW'(coin) + SW'(pay_tick);
    if (state_q == ST_DEBIT) begin
      csum = csum - SW'(bet_q);
    end
    credits_d = (csum[SW-1:CREDIT_W] != '0) ? '1 : csum[CREDIT_W-1:0];

    gui_deal_d = (state_d == ST_DEBIT);
    gui_draw_d = (state_q == ST_HOLD) && draw_req;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      credits_q  <= '0;
      win_q      <= '0;
      bet_q      <= 3'd1;
      gui_deal_q <= 1'b0;
      gui_draw_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      win_q      <= win_d;
      bet_q      <= bet_d;
      gui_deal_q <= gui_deal_d;
      gui_draw_q <= gui_draw_d;
      busy_q     <= busy_d;
    end
  end

  assign gui_deal = gui_deal_q;
  assign gui_draw = gui_draw_q;
  assign credits  = credits_q;
  assign bet      = bet_q;
  assign win      = win_q;
  assign state    = state_q;
  assign busy     = busy_q;

endmodule

// File: doc/vp_game_ctrl.md
# vp_game_ctrl

Round sequencer and credit manager for the video poker machine. Sits between the player buttons/coin input and the `play`/`resolver` pair. Accepts credits and bet selection, and starts a deal by debiting the bet and pulsing `gui_deal`. It then waits for the hand, issues `gui_draw`, captures the resolver's hand value and pays `bet × multiplier` back into the credit counter one credit per cycle.

## Interface
- `CREDIT_W`, 12: credit counter width; credits saturate at 2^CREDIT_W−1.
- `MAX_BET`, 5: largest selectable bet, valid range 1..7.
- `HOLD_TIMEOUT`, 1000: cycles in HOLD before auto-draw; used only with `VP_AUTO_DRAW_EN`.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `coin`, in, 1: one-cycle pulse adds 1 credit.
- `bet_btn`, in, 1: pulse; advances the bet 1→2→…→MAX_BET→1. Honoured only in IDLE.
- `deal_btn`, in, 1: pulse; starts a round.
- `draw_btn`, in, 1: pulse; ends the hold phase.
- `dealt`, in, 1: pulse from `play` when the 5-card hand is complete.
- `resolved`, in, 1: pulse from `resolver`; `value` is valid in the same cycle.
- `value`, in, 4: hand rank 0..9.
- `gui_deal`, out, 1: one-cycle deal request to `play`.
- `gui_draw`, out, 1: one-cycle draw request to `play`.
- `credits`, out, CREDIT_W: current credit count.
- `bet`, out, 3: current bet.
- `win`, out, CREDIT_W: payout of the last round; held until the next deal.
- `state`, out, 3: FSM state encoding for GUI/debug.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE=0, DEBIT=1, WAIT_DEAL=2, HOLD=3, WAIT_RES=4, PAYOUT=5.
- **IDLE**
  - `deal_btn` with `credits >= bet` → DEBIT.
  - `deal_btn` with `credits < bet` is ignored.
  - `bet_btn` updates `bet`.
- **DEBIT** (1 cycle)
  - `credits -= bet`, `win` cleared to 0, `gui_deal`=1 → WAIT_DEAL.
- **WAIT_DEAL**: `dealt` → HOLD.
- **HOLD**: `draw_btn` → WAIT_RES, with `gui_draw`=1 in the transition cycle.
- **WAIT_RES**: on `resolved`, latch `win = bet × mult(value)` and load the remaining-payout counter with the same value → PAYOUT.
- **PAYOUT**
  - Each cycle: remaining −1, `credits` +1 (saturating).
  - The cycle the remaining count is 0 → IDLE. A zero win therefore spends exactly one cycle in PAYOUT.
- Multipliers by `value` 0..9: 0, 1, 2, 3, 4, 6, 9, 25, 50, 250. Values 10..15 use multiplier 0.
- Arithmetic:
  - Product is at most 7×250 = 1750 and fits 11 bits.
  - `win` truncation is impossible for CREDIT_W ≥ 11; CREDIT_W < 11 is illegal.
- `coin` is accepted in every state.
  - Coin in the same cycle as a payout tick: `credits` +2, saturating.
  - Coin in DEBIT: net change is `+1 − bet`.
- Button pulses that do not match the current state are ignored. They are not queued.

## Timing
- Reset values: state IDLE, `credits`=0, `bet`=1, `win`=0, `gui_deal`=0, `gui_draw`=0, `busy`=0.
- Reset mid-round returns to IDLE next cycle. The bet already debited is lost.
- All outputs are registered.
- `gui_deal` is high in the single DEBIT cycle, i.e. 1 cycle after `deal_btn` is sampled.
- `gui_draw` is high 1 cycle after `draw_btn` is sampled.
- `dealt`/`resolved` arriving in any state other than WAIT_DEAL/WAIT_RES are ignored.
- Payout latency: `win` valid 1 cycle after `resolved`. Credits finish updating `win` cycles after entering PAYOUT; IDLE follows on the next cycle.
- Round length from `deal_btn` to IDLE: 1 + dealt latency + hold time + resolve latency + `win` + 1 cycles.

## Configuration
- `VP_AUTO_DRAW_EN` defined:
  - A hold counter clears on HOLD entry and increments each HOLD cycle.
  - At HOLD_TIMEOUT−1 the block behaves exactly as if `draw_btn` were pulsed.
  - `draw_btn` before the timeout still wins.
- `VP_AUTO_DRAW_EN` undefined: no counter logic; HOLD waits indefinitely for `draw_btn`.

## Structure
- Shared package `vp_pkg` holds:
  - the state enum/localparams;
  - the hand-value constants 0..9;
  - the payout multiplier function/table, which `resolver`-side display logic also uses.
- One sub-module, `vp_payout_ctr`: the load/decrement remaining-payout counter with its done flag.
- FSM, credit adder/saturation and bet register stay in the top module.

## Test plan
- Reset, 3 `coin` pulses, `bet_btn` twice → `credits`=3, `bet`=3, state IDLE.
- `bet_btn` ×5 from bet=1 with MAX_BET=5 → bet sequence 2, 3, 4, 5, 1.
- `credits`=2, `bet`=3, `deal_btn` → no `gui_deal`, state stays IDLE, `credits`=2.
- `credits`=10, `bet`=2, full round with `value`=6 → `gui_deal` next cycle, `credits`=8, `win`=18. PAYOUT lasts 18 ticks, ending at `credits`=26, then IDLE.
- `credits`=4094 (CREDIT_W=12), win 4, `coin` pulsed during PAYOUT → `credits` saturates at 4095.
- With `VP_AUTO_DRAW_EN` and HOLD_TIMEOUT=8, no `draw_btn` → `gui_draw` 8 cycles after HOLD entry.
- Reset asserted in WAIT_RES → IDLE, `credits`=0, `resolved` afterwards ignored.
